// File: rtl/uart_rx_fifo_controller.sv
// UART receiver with 3-sample majority voting, configurable frame format,
// break detection and a show-ahead receive FIFO that carries per-character
// parity/frame flags alongside the data.
// The receiver samples the pin through a two-flop synchroniser. It counts
// oversampling phases on baud_tick and writes each completed character into
// the FIFO. The FIFO head is held in registers, so the head character and
// its flags come straight from flops.

module uart_rx_fifo_controller #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          Clk,
  input  logic                          Resetn,
  input  logic                          Enable,
  input  logic                          baud_tick,
  input  logic                          UART_RX_I,
  input  logic                          Unload_data,
  input  logic                          Clear_status,
  output logic [DATA_BITS-1:0]          RX_data,
  output logic                          Parity_error,
  output logic                          Frame_error,
  output logic                          Empty,
  output logic                          Full,
  output logic [$clog2(FIFO_DEPTH):0]   Level,
  output logic                          Overrun,
  output logic                          Break_detect
);

  // ---------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------
  localparam int PH_W    = $clog2(OVERSAMPLE);
  localparam int BC_W    = $clog2(DATA_BITS + 1);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int ENTRY_W = DATA_BITS + 2;

  localparam logic [PH_W-1:0]  PH_VOTE0  = PH_W'(OVERSAMPLE / 2 - 1);
  localparam logic [PH_W-1:0]  PH_VOTE1  = PH_W'(OVERSAMPLE / 2);
  localparam logic [PH_W-1:0]  PH_DECIDE = PH_W'(OVERSAMPLE / 2 + 1);
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0]  BC_LAST   = BC_W'(DATA_BITS);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
  localparam logic [1:0]       PMODE     = 2'(PARITY_MODE);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_t;

  // Parity check of a received character: returns 1 when the ones count of
  // data plus parity bit disagrees with the configured mode.
  function automatic logic parity_err_f(input logic [DATA_BITS-1:0] d,
                                        input logic                 p);
    logic ones_odd;
    ones_odd = ^{d, p};
    case (PMODE)
      2'd1:    return ones_odd;
      2'd2:    return ~ones_odd;
      default: return 1'b0;
    endcase
  endfunction

  // ---------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------
  logic                 sync1_r, sync2_r, rx_s;
  state_t               state_r, state_nxt_s;
  logic [PH_W-1:0]      ph_r;
  logic                 vote0_r, vote1_r;
  logic [BC_W-1:0]      bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 par_bit_r;
  logic                 stop_idx_r;
  logic                 fe_acc_r;

  logic                 frame_tick_s, decide_s, bit_end_s, maj_s;
  logic                 last_stop_s, break_cond_s;
  logic                 start_s, shift_en_s, par_cap_s, stop_acc_s, stop_adv_s;
  logic                 wr_req_s, brk_set_s;
  logic                 pe_s, fe_s;
  logic [ENTRY_W-1:0]   wr_word_s;

  logic [ENTRY_W-1:0]   mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r, rd_ptr_nxt_s;
  logic [LVL_W-1:0]     level_r, level_nxt_s;
  logic                 empty_r, full_r;
  logic [ENTRY_W-1:0]   head_r, head_nxt_s;
  logic                 pop_s, push_s, ovr_set_s;
  logic                 overrun_r, break_r;

  // ---------------------------------------------------------------------
  // Input synchroniser and bit-timing decode
  // ---------------------------------------------------------------------
  // Two-flop synchroniser on the asynchronous pin; idles at mark level.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= UART_RX_I;
      sync2_r <= sync1_r;
    end
  end

  assign rx_s         = sync2_r;
  assign frame_tick_s = baud_tick && (state_r != ST_IDLE);
  assign decide_s     = frame_tick_s && (ph_r == PH_DECIDE);
  assign bit_end_s    = frame_tick_s && (ph_r == PH_LAST);
  // The third vote is the live sample on the decision tick.
  assign maj_s        = (vote0_r & vote1_r) | (vote0_r & rx_s) | (vote1_r & rx_s);
  assign last_stop_s  = (stop_idx_r == STOP_LAST);
  // A break needs an all-zero character, a zero parity bit (if any) and a
  // zero first stop bit.
  assign break_cond_s = (shift_r == '0) &&
                        ((PMODE == 2'd0) || (par_bit_r == 1'b0)) &&
                        (maj_s == 1'b0) && (stop_idx_r == 1'b0);

  assign pe_s      = parity_err_f(shift_r, par_bit_r);
  assign fe_s      = fe_acc_r | ~maj_s;
  assign wr_word_s = {fe_s, pe_s, shift_r};

  // ---------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------
  // FSM state register.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic. Dropping Enable abandons any character in flight.
  always_comb begin
    state_nxt_s = state_r;
    if (!Enable) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!rx_s) state_nxt_s = ST_START;
          else       state_nxt_s = ST_IDLE;
        end
        ST_START: begin
          if (decide_s && maj_s) state_nxt_s = ST_IDLE;
          else if (bit_end_s)    state_nxt_s = ST_DATA;
          else                   state_nxt_s = ST_START;
        end
        ST_DATA: begin
          if (bit_end_s && (bit_cnt_r == BC_LAST))
            state_nxt_s = (PMODE != 2'd0) ? ST_PARITY : ST_STOP;
          else
            state_nxt_s = ST_DATA;
        end
        ST_PARITY: begin
          if (bit_end_s) state_nxt_s = ST_STOP;
          else           state_nxt_s = ST_PARITY;
        end
        ST_STOP: begin
          // Complete on the final stop bit's decision, not at its end, so
          // the receiver can resync to a start bit that arrives early.
          if (decide_s && break_cond_s)     state_nxt_s = ST_BREAK;
          else if (decide_s && last_stop_s) state_nxt_s = ST_IDLE;
          else                              state_nxt_s = ST_STOP;
        end
        ST_BREAK: begin
          if (rx_s) state_nxt_s = ST_IDLE;
          else      state_nxt_s = ST_BREAK;
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // FSM control outputs that drive the bit datapath, FIFO write and flags.
  always_comb begin
    start_s    = 1'b0;
    shift_en_s = 1'b0;
    par_cap_s  = 1'b0;
    stop_acc_s = 1'b0;
    stop_adv_s = 1'b0;
    wr_req_s   = 1'b0;
    brk_set_s  = 1'b0;
    if (Enable) begin
      case (state_r)
        ST_IDLE:   start_s    = ~rx_s;
        ST_DATA:   shift_en_s = decide_s;
        ST_PARITY: par_cap_s  = decide_s;
        ST_STOP: begin
          if (decide_s) begin
            if (break_cond_s)     brk_set_s  = 1'b1;
            else if (last_stop_s) wr_req_s   = 1'b1;
            else                  stop_acc_s = 1'b1;
          end else begin
            stop_adv_s = bit_end_s;
          end
        end
        default: start_s = 1'b0;
      endcase
    end else begin
      start_s = 1'b0;
    end
  end

  // Bit-level datapath: phase counter, votes, data shifter and stop tracking.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      ph_r       <= '0;
      vote0_r    <= 1'b0;
      vote1_r    <= 1'b0;
      bit_cnt_r  <= '0;
      shift_r    <= '0;
      par_bit_r  <= 1'b0;
      stop_idx_r <= 1'b0;
      fe_acc_r   <= 1'b0;
    end else if (start_s) begin
      ph_r       <= '0;
      vote0_r    <= 1'b0;
      vote1_r    <= 1'b0;
      bit_cnt_r  <= '0;
      shift_r    <= '0;
      par_bit_r  <= 1'b0;
      stop_idx_r <= 1'b0;
      fe_acc_r   <= 1'b0;
    end else begin
      if (frame_tick_s)
        ph_r <= (ph_r == PH_LAST) ? '0 : ph_r + PH_W'(1);
      if (frame_tick_s && (ph_r == PH_VOTE0))
        vote0_r <= rx_s;
      if (frame_tick_s && (ph_r == PH_VOTE1))
        vote1_r <= rx_s;
      if (shift_en_s) begin
        shift_r   <= {maj_s, shift_r[DATA_BITS-1:1]};
        bit_cnt_r <= bit_cnt_r + BC_W'(1);
      end
      if (par_cap_s)
        par_bit_r <= maj_s;
      if (stop_acc_s)
        fe_acc_r <= fe_acc_r | ~maj_s;
      if (stop_adv_s)
        stop_idx_r <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Receive FIFO with registered show-ahead head
  // ---------------------------------------------------------------------
  assign pop_s     = Unload_data & ~empty_r;
  // A write into a full FIFO still succeeds when a pop frees a slot on the
  // same edge.
  assign push_s    = wr_req_s & (~full_r | pop_s);
  assign ovr_set_s = wr_req_s & full_r & ~pop_s;

  // Next read pointer, level and head entry after this cycle's push/pop.
  always_comb begin
    rd_ptr_nxt_s = rd_ptr_r;
    level_nxt_s  = level_r;
    head_nxt_s   = '0;
    if (pop_s) rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
    else       rd_ptr_nxt_s = rd_ptr_r;
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LVL_W'(1);
      2'b01:   level_nxt_s = level_r - LVL_W'(1);
      default: level_nxt_s = level_r;
    endcase
    // The new head is the entry being written when it lands in the slot
    // the read pointer moves to, otherwise it comes from storage.
    if (level_nxt_s == '0)                          head_nxt_s = '0;
    else if (push_s && (rd_ptr_nxt_s == wr_ptr_r))  head_nxt_s = wr_word_s;
    else                                            head_nxt_s = mem_r[rd_ptr_nxt_s];
  end

  // FIFO storage write port.
  always_ff @(posedge Clk) begin
    if (push_s) mem_r[wr_ptr_r] <= wr_word_s;
  end

  // FIFO pointers, occupancy and the registered head entry.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
      head_r   <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      rd_ptr_r <= rd_ptr_nxt_s;
      level_r  <= level_nxt_s;
      empty_r  <= (level_nxt_s == '0);
      full_r   <= (level_nxt_s == LVL_FULL);
      head_r   <= head_nxt_s;
    end
  end

  // Sticky status flags. A set event beats a clear in the same cycle.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      overrun_r <= 1'b0;
      break_r   <= 1'b0;
    end else begin
      if (ovr_set_s)         overrun_r <= 1'b1;
      else if (Clear_status) overrun_r <= 1'b0;
      if (brk_set_s)         break_r   <= 1'b1;
      else if (Clear_status) break_r   <= 1'b0;
    end
  end

  assign RX_data      = head_r[DATA_BITS-1:0];
  assign Parity_error = head_r[DATA_BITS];
  assign Frame_error  = head_r[DATA_BITS+1];
  assign Empty        = empty_r;
  assign Full         = full_r;
  assign Level        = level_r;
  assign Overrun      = overrun_r;
  assign Break_detect = break_r;

endmodule

// File: doc/uart_rx_fifo_controller.md
# uart_rx_fifo_controller

Parametrised UART receiver with oversampled majority-vote bit sampling, configurable frame format (data bits, parity, stop bits), break detection and a show-ahead receive FIFO that stores per-character error flags. It sits between the UART RX pin and the AXI-Lite register front end and consumes the shared oversampling `baud_tick` from the baud generator. It replaces the single-buffer receiver where bursts must be absorbed without CPU intervention.

## Interface
- `DATA_BITS`, 8: character width, legal 5..9.
- `PARITY_MODE`, 0: 0 none, 1 even, 2 odd.
- `STOP_BITS`, 1: 1 or 2.
- `OVERSAMPLE`, 16: `baud_tick` pulses per bit; even, >= 8. H = OVERSAMPLE/2.
- `FIFO_DEPTH`, 8: entries, power of 2, >= 2.
- `Clk` in 1: single clock, all logic on rising edge.
- `Resetn` in 1: asynchronous, active-low reset.
- `Enable` in 1: receiver enable.
- `baud_tick` in 1: one-`Clk` pulse at OVERSAMPLE x baud rate.
- `UART_RX_I` in 1: asynchronous serial input, idle high.
- `Unload_data` in 1: pop FIFO head.
- `Clear_status` in 1: clear sticky flags.
- `RX_data` out DATA_BITS: head character; 0 when `Empty`.
- `Parity_error` out 1: head entry's parity flag; 0 when `Empty`.
- `Frame_error` out 1: head entry's stop-bit flag; 0 when `Empty`.
- `Empty`, `Full` out 1: FIFO status.
- `Level` out $clog2(FIFO_DEPTH)+1: entry count, 0..FIFO_DEPTH.
- `Overrun` out 1: sticky, character dropped because FIFO full.
- `Break_detect` out 1: sticky, break condition received.

## Operation
- Input: 2-flop synchroniser, then majority logic on synchronised value `rx_s`.
- Phase counter `ph` (0..OVERSAMPLE-1) advances only on `baud_tick`. Vote samples are taken on ticks where `ph` = H-1, H, H+1. Bit value = majority of 3, decided on the tick with `ph` = H+1. `ph` wrapping from OVERSAMPLE-1 to 0 ends the bit.
- States:
  - **IDLE**: when `Enable` and `rx_s`=0, clear `ph` and votes, go to START.
  - **START**: on decision, majority 1 (false start) goes to IDLE with nothing written. Majority 0 goes to DATA at the end of the bit.
  - **DATA**: decided bits are shifted in LSB first. After DATA_BITS bits, go to PARITY (if PARITY_MODE != 0) or STOP.
  - **PARITY**: even mode flags an error if the ones count of data+parity is odd; odd mode flags an error if it is even.
  - **STOP**: each stop bit must decide 1, otherwise frame error. On the final stop bit's decision (not the end of the bit) the character completes and the state returns to IDLE, for early resync.
  - **BREAK_WAIT**: stays until `rx_s`=1, then goes to IDLE.
- Break: data all 0, parity bit (if any) 0, and first stop bit 0 sets `Break_detect` and enters BREAK_WAIT. No FIFO write.
- Completion otherwise: write {Frame_error, Parity_error, data} into the FIFO. Errored characters are stored, not dropped.
- FIFO write when full: if `Unload_data` is also asserted that cycle, pop and write both succeed, `Level` is unchanged, and there is no overrun. Otherwise the character is discarded, `Overrun` is set, and the contents are unchanged.
- `Unload_data` while `Empty` is ignored.
- Sticky flags: `Clear_status` clears `Overrun` and `Break_detect`. A set event in the same cycle wins.
- `Enable` low: the FSM goes to IDLE on the next edge and any partial character is discarded. FIFO and flags are unaffected.
- Pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally.

## Timing
- Reset values:
  - `RX_data` 0, `Parity_error` 0, `Frame_error` 0.
  - `Empty` 1, `Full` 0, `Level` 0.
  - `Overrun` 0, `Break_detect` 0.
  - FSM in IDLE, pointers 0, synchroniser flops 1.
- Reset asserted mid-character: all of the above apply immediately. The partial character is lost.
- Pin to `rx_s` latency: 2 `Clk`.
- Write commit: on the edge that ends the decision cycle. `Empty`, `Level` and `RX_data` update on that same edge (registered show-ahead head), visible the following cycle.
- Pop: `Unload_data` sampled high at an edge. The head advances, and `Level`, `Full` and `Empty` update on that edge.
- Flags (`Overrun`, `Break_detect`) assert on the same edge as the triggering decision.

## Test plan
Common setup: DATA_BITS=8, PARITY_MODE=0, STOP_BITS=1, OVERSAMPLE=16, FIFO_DEPTH=8, `baud_tick` every 4 `Clk` (64 `Clk` per bit).
- Send 0x55 then 0xA3, no pops -> `Level`=2, `RX_data`=0x55 with flags 0. First pop gives 0xA3. Second pop gives `Empty`=1 and `RX_data`=0.
- PARITY_MODE=1, send 0x07 with parity bit 0 -> head entry 0x07, `Parity_error`=1, `Frame_error`=0. Repeat with parity 1 -> both flags 0.
- Low glitch of 5 `baud_tick` on idle line -> no write, `Level`=0, FSM back in IDLE. Send 0x3C with the stop bit forced 0 (data not all 0) -> entry 0x3C with `Frame_error`=1.
- Nine characters 0x01..0x09, no pops -> `Full`=1, `Level`=8, `Overrun`=1, head 0x01. `Clear_status` -> `Overrun`=0. Ninth character sent with `Unload_data` pulsed at its commit cycle -> no overrun, `Level` stays 8.
- Line held low for 12 bit times, then high, then 0x3C sent -> `Break_detect`=1, `Level` 0 then 1, head 0x3C.
- `Enable` dropped at data bit 3 of 0xF0 -> no write. Assert `Resetn`=0 mid-character with `Level`=3 -> all outputs at reset values immediately.
